// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD display path: segment glyphs and
// the decimal digit count helper used to size BCD words.
package bcd_pkg;

    // Active-high segment patterns, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_E    = 7'h79;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Decimal digits needed to hold any unsigned value of 'width' bits:
    // floor(width * log10(2)) + 1, with log10(2) scaled by 1e5.
    function automatic int bcd_digits(input int width);
        if (width <= 0)
            return 1;
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble-to-glyph decoder. Dash overrides everything,
// nibbles above 9 render as 'E'.
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       force_dash,
    output logic [6:0] pattern
);

    // Glyph selection in priority order: dash, decimal glyph, error.
    always_comb begin
        pattern = SEG_E;
        if (force_dash)
            pattern = SEG_DASH;
        else if (nibble <= 4'd9)
            pattern = SEG_DIGIT[nibble];
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed 7-segment scanner for a captured BCD word. One digit is
// driven per slot of PRESCALE cycles; the first BLANK cycles of each
// slot keep all digit enables off so the previous glyph cannot ghost
// onto the newly selected digit.
module bcd_display_scan
    import bcd_pkg::*;
#(
    parameter int DECLEN   = 9,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DECLEN*4-1:0]   BCD,
    input  logic                  ovf,
    input  logic                  load,
    output logic [6:0]            SEG,
    output logic [DECLEN-1:0]     DIGIT,
    output logic                  active
);

    // Guard against zero-width counters for degenerate parameter values.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DECLEN > 1) ? $clog2(DECLEN) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DECLEN - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK);

    logic [DECLEN*4-1:0] word_reg;
    logic                ovf_reg;
    logic                active_reg;
    logic [PW-1:0]       presc_reg, presc_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [6:0]          seg_reg, seg_next;
    logic [DECLEN-1:0]   digit_reg, digit_next;

    logic [3:0]          nib [DECLEN];
    logic [DECLEN-1:0]   zero_from;
    logic [DECLEN-1:0]   onehot;
    logic [3:0]          cur_nib;
    logic [6:0]          glyph;
    logic                lz_blank;
    logic                in_blank;

    // Per-digit views of the captured word: the nibble itself, whether
    // this digit and everything above it is zero, and the one-hot enable.
    // Invalid nibbles are non-zero, so they never count as leading zeros.
    genvar gi;
    generate
        for (gi = 0; gi < DECLEN; gi++) begin : g_digit
            assign nib[gi]       = word_reg[gi*4 +: 4];
            assign zero_from[gi] = (word_reg[DECLEN*4-1 : gi*4] == '0);
            assign onehot[gi]    = (idx_reg == IW'(gi));
        end
    endgenerate

    assign cur_nib  = nib[idx_reg];
    assign lz_blank = (idx_reg != '0) && zero_from[idx_reg];
    assign in_blank = (presc_reg < BLANK_END);

    bcd_to_seg7 u_seg7 (
        .nibble     (cur_nib),
        .force_dash (ovf_reg),
        .pattern    (glyph)
    );

    // Slot timing: prescaler wraps at PRESCALE-1 and steps the digit index.
    always_comb begin
        presc_next = presc_reg;
        idx_next   = idx_reg;
        if (active_reg) begin
            if (presc_reg == PRESC_MAX) begin
                presc_next = '0;
                idx_next   = (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end
    end

    // Next output pattern for the current slot; overflow dashes win over
    // leading-zero blanking so every position shows the dash.
    always_comb begin
        seg_next   = SEG_OFF;
        digit_next = '0;
        if (active_reg && !(lz_blank && !ovf_reg)) begin
            seg_next   = glyph;
            digit_next = in_blank ? '0 : onehot;
        end
    end

    // Capture, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg   <= '0;
            ovf_reg    <= 1'b0;
            active_reg <= 1'b0;
            presc_reg  <= '0;
            idx_reg    <= '0;
            seg_reg    <= SEG_OFF;
            digit_reg  <= '0;
        end else begin
            if (load) begin
                word_reg   <= BCD;
                ovf_reg    <= ovf;
                active_reg <= 1'b1;
            end
            presc_reg <= presc_next;
            idx_reg   <= idx_next;
            seg_reg   <= seg_next;
            digit_reg <= digit_next;
        end
    end

    assign SEG    = seg_reg;
    assign DIGIT  = digit_reg;
    assign active = active_reg;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized bench for bcd_display_scan with a behavioural scan model:
// expected outputs come from elapsed scan time and the captured value.
module tb_bcd_display_scan;

    localparam int DECLEN   = 9;
    localparam int PRESCALE = 4;
    localparam int BLANK    = 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [DECLEN*4-1:0] BCD = '0;
    logic                ovf = 1'b0;
    logic                load = 1'b0;
    logic [6:0]          SEG;
    logic [DECLEN-1:0]   DIGIT;
    logic                active;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit                m_active;
    bit [DECLEN*4-1:0] m_word;
    bit                m_ovf;
    int                m_tick;

    bit [6:0] glyph_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_display_scan #(
        .DECLEN   (DECLEN),
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .BCD    (BCD),
        .ovf    (ovf),
        .load   (load),
        .SEG    (SEG),
        .DIGIT  (DIGIT),
        .active (active)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Outputs implied by the model's current scan time and captured value.
    function automatic void model_expect(output bit [6:0] es, output bit [DECLEN-1:0] ed);
        int idx, pos;
        bit [DECLEN*4-1:0] upper;
        int nibv;
        es = 7'h00;
        ed = '0;
        if (!m_active)
            return;
        idx   = (m_tick / PRESCALE) % DECLEN;
        pos   = m_tick % PRESCALE;
        upper = m_word >> (4 * idx);
        nibv  = int'(upper[3:0]);
        if (m_ovf)
            es = 7'h40;
        else if (idx != 0 && upper == 0)
            return;
        else if (nibv > 9)
            es = 7'h79;
        else
            es = glyph_tbl[nibv];
        ed = (pos < BLANK) ? '0 : (DECLEN'(1) << idx);
    endfunction

    task automatic model_clear();
        m_active = 1'b0;
        m_word   = '0;
        m_ovf    = 1'b0;
        m_tick   = 0;
    endtask

    // One clock edge: predict from pre-edge state, advance the model, compare.
    task automatic step();
        bit [6:0]        es;
        bit [DECLEN-1:0] ed;
        @(posedge clk);
        if (rst) begin
            model_clear();
            es = '0;
            ed = '0;
        end else begin
            model_expect(es, ed);
            if (m_active)
                m_tick++;
            if (load) begin
                m_word   = BCD;
                m_ovf    = ovf;
                m_active = 1'b1;
            end
        end
        #1;
        check_val("seg", 32'(SEG), 32'(es));
        check_val("digit", 32'(DIGIT), 32'(ed));
        check_val("active", 32'(active), 32'(m_active));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic load_word(input bit [DECLEN*4-1:0] w, input bit o);
        BCD  = w;
        ovf  = o;
        load = 1'b1;
        $display("load BCD=0x%09h ovf=%0d at scan tick %0d", w, o, m_tick);
        step();
        load = 1'b0;
    endtask

    // Asynchronous reset: outputs must drop before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        check_val("rst_seg", 32'(SEG), 32'h0);
        check_val("rst_digit", 32'(DIGIT), 32'h0);
        check_val("rst_active", 32'(active), 32'h0);
        step();
        rst = 1'b0;
    endtask

    function automatic bit [DECLEN*4-1:0] rand_word();
        bit [DECLEN*4-1:0] w;
        int k;
        w = '0;
        k = $urandom_range(0, DECLEN);
        for (int i = 0; i < k; i++) begin
            if ($urandom_range(0, 9) == 0)
                w[i*4 +: 4] = 4'($urandom_range(10, 15));
            else
                w[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    initial begin
        int guard;
        model_clear();
        #2;
        do_reset();

        // Idle: nothing lights until the first load
        run(50);

        // Case A: 12345 with leading zeros
        load_word(36'h000012345, 1'b0);
        run(40);

        // Case B: value zero shows a single '0'
        do_reset();
        load_word(36'h000000000, 1'b0);
        run(40);

        // Case C: overflow dashes on every digit
        do_reset();
        load_word(rand_word(), 1'b1);
        run(40);

        // Case D: invalid nibble shows 'E', above it blanked
        do_reset();
        load_word(36'h0000000A0, 1'b0);
        run(40);

        // Reload while scanning: counters undisturbed, new data within 2 edges
        do_reset();
        load_word(36'h000000001, 1'b0);
        step();
        load_word(36'h000000007, 1'b0);
        step();
        step();
        check_val("reload_seg", 32'(SEG), 32'h07);
        run(10);

        // Load landing exactly on a prescaler wrap edge
        guard = 0;
        while ((m_tick % PRESCALE) != PRESCALE - 1 && guard < PRESCALE) begin
            step();
            guard++;
        end
        load_word(rand_word(), 1'b0);
        run(40);

        // Reset mid-slot at index 3, then restart from index 0
        do_reset();
        load_word(36'h987654321, 1'b0);
        run(3 * PRESCALE + 2);
        check_val("pre_rst_digit", 32'(DIGIT), 32'h008);
        do_reset();
        run(5);
        load_word(rand_word(), 1'b0);
        run(40);

        // Random loads at random times, including repeated loads while active
        for (int n = 0; n < 20; n++) begin
            run($urandom_range(0, 12));
            load_word(rand_word(), ($urandom_range(0, 7) == 0));
        end
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the combinational binary-to-BCD converter.
- Captures a packed BCD word plus its overflow flag on a load strobe.
- Time-multiplexes the captured digits onto one shared 7-segment bus with one-hot digit enables.
- Features: leading-zero suppression, invalid-digit marking, overflow dash display, and an inter-digit blanking gap to prevent ghosting.

Parameters:
- DECLEN, 9, number of BCD digits; matches the converter's digit count.
- PRESCALE, 1000, clock cycles per digit slot; must be ≥ 2.
- BLANK, 2, cycles at the start of each slot with DIGIT forced to 0; must be < PRESCALE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- BCD  input  DECLEN*4  packed digits; digit i = BCD[i*4+:4]; digit 0 is the least significant.
- ovf  input  1  overflow flag from the converter; sampled together with BCD.
- load  input  1  capture strobe; samples BCD and ovf on a rising edge of clk while high.
- SEG  output  7  segment drive, active high; SEG[0]=a … SEG[6]=g.
- DIGIT  output  DECLEN  one-hot digit enable, active high; bit i selects digit i.
- active  output  1  high once the first load has been captured.

Behaviour:
- Reset (async, rst=1), everything cleared immediately:
  - Captured word = 0, captured ovf = 0.
  - Digit index = 0, prescaler = 0, active = 0.
  - SEG = 0, DIGIT = 0.
- While active = 0:
  - Counters hold at 0; SEG = 0 and DIGIT = 0.
  - The first load sets active = 1 on the same edge that captures the data.
- Capture:
  - On an edge with load = 1, the captured word becomes BCD and captured ovf becomes ovf.
  - A load while already active does not disturb the index or prescaler; scanning continues.
  - New data appears on SEG no later than the second edge after the load edge.
- Prescaler:
  - Counts 0..PRESCALE-1 while active, then wraps to 0.
  - On wrap, the index advances 0→1→…→DECLEN-1→0.
- Outputs are registered and computed from the current index, prescaler and captured state:
  - DIGIT = 0 while prescaler < BLANK; otherwise DIGIT = one-hot(index).
  - SEG holds the pattern for the current index for the whole slot, including the blanking cycles.
- Per-digit pattern, priority order:
  1. Captured ovf = 1: dash (0x40) on every digit.
  2. Nibble > 9: 'E' (0x79).
  3. Leading-zero blank: SEG = 0 and DIGIT = 0 for the whole slot when index ≠ 0 and all captured digits index..DECLEN-1 are zero. Digit 0 always displays, so a value of 0 shows a single '0'.
  4. Otherwise the decimal glyph: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- An invalid nibble counts as non-zero for leading-zero evaluation.
- A load landing exactly on a prescaler wrap edge:
  - The index advances and the new data is used.
  - No slot is lost or repeated.
- Reset asserted mid-scan: all state clears immediately; scanning stays stopped until the next load.
- Counter widths: $clog2(PRESCALE) for the prescaler, $clog2(DECLEN) for the index. Both max values are explicit wrap points, so non-power-of-2 parameters must wrap correctly.

Decomposition:
- Shared package bcd_pkg holds:
  - The segment-pattern constants: SEG_DIGIT[0:9], SEG_E, SEG_DASH, SEG_OFF.
  - A function returning the digit count for a binary width, shared with the converter's size include.
- One combinational sub-module, bcd_to_seg7:
  - Inputs: 4-bit nibble and a force_dash flag.
  - Output: 7-bit pattern.
  - Instantiated once on the muxed nibble.
- The top level holds the capture register, counters, leading-zero logic and output registers.

Test Plan:
- Reset then idle, no load for 50 cycles → SEG=0, DIGIT=0, active=0 throughout.
- Reset and post-load checks:
  - Case A (DECLEN=9, PRESCALE=4, BLANK=1): load BCD=0x000012345, ovf=0 → DIGIT cycles through 0x001, 0x002, 0x004, 0x008, 0x010 with SEG 0x6D, 0x66, 0x4F, 0x5B, 0x06. Digits 5–8 have DIGIT=0 and SEG=0. Each slot is 4 cycles with DIGIT=0 in its first cycle.
  - Case B: load BCD=0 → only digit 0 lights with 0x3F; every other slot is dark.
  - Case C: load ovf=1 with any BCD → every slot lights with SEG=0x40.
  - Case D: load BCD=0x0000000A0 → digit 0 shows 0x3F, digit 1 shows 0x79, digits 2–8 are blanked.
- Load 0x000000001 mid-slot at index 0, then 0x000000007 two cycles later → index and prescaler are undisturbed; SEG=0x07 within 2 edges of the second load.
- Assert rst for 1 cycle at index 3 mid-slot → SEG=0 and DIGIT=0 asynchronously. After a new load, scanning restarts at index 0 with prescaler 0.
